// File: rtl/cfu_burst_initiator_pkg.sv
// -----------------------------------------------------------------------------
// cfu_burst_initiator_pkg
// Shared CFU definitions: payload widths, function-id constants and the
// burst-initiator state encoding.
// -----------------------------------------------------------------------------
package cfu_burst_initiator_pkg;

  localparam int CFU_FN_W   = 10;
  localparam int CFU_DATA_W = 32;

  localparam logic [CFU_FN_W-1:0] FN_READ  = 10'd0;
  localparam logic [CFU_FN_W-1:0] FN_WRITE = 10'd1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/cfu_burst_initiator.sv
// -----------------------------------------------------------------------------
// cfu_burst_initiator
// Issues a burst of single-outstanding CFU commands (read or write) to
// consecutive word addresses, accumulates the responses and reports
// completion or a response timeout.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start, op             burst request (sampled in IDLE), 1 = write / 0 = read
//   base_addr, count      first address and number of commands
//   seed                  write data for index 0 (index i uses seed+i)
//   busy, done, error     status: not IDLE / one-cycle completion / sticky timeout
//   sum, last_rsp         running response sum and latest response word
//   cmd_*, rsp_*          CFU initiator command and response channels
// -----------------------------------------------------------------------------
module cfu_burst_initiator
  import cfu_burst_initiator_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [15:0]           count,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           sum,
  output logic [31:0]           last_rsp,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [CFU_FN_W-1:0]   cmd_payload_function_id,
  output logic [CFU_DATA_W-1:0] cmd_payload_inputs_0,
  output logic [CFU_DATA_W-1:0] cmd_payload_inputs_1,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [CFU_DATA_W-1:0] rsp_payload_outputs_0
);

  // Timeout counter runs 0..TIMEOUT-1 across the WAIT_RSP cycles.
  localparam int                TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e                  r_state;
  state_e                  w_next;

  logic                    r_op;
  logic [ADDR_W-1:0]       r_base;
  logic [15:0]             r_count;
  logic [31:0]             r_seed;
  logic [15:0]             r_idx;
  logic [TMO_W-1:0]        r_tmo;
  logic [31:0]             r_sum;
  logic [31:0]             r_last;
  logic                    r_error;

  logic                    w_accept;
  logic                    w_cmd_fire;
  logic                    w_rsp_fire;
  logic                    w_tmo_hit;
  logic                    w_last_cmd;
  logic [ADDR_W-1:0]       w_addr;

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_cmd_fire = (r_state == ST_ISSUE) && cmd_ready;
  // rsp_ready is 1 throughout WAIT_RSP, so rsp_valid alone completes the handshake.
  assign w_rsp_fire = (r_state == ST_WAIT_RSP) && rsp_valid;
  // A response in the final allowed cycle still wins over the timeout.
  assign w_tmo_hit  = (r_state == ST_WAIT_RSP) && !rsp_valid && (r_tmo == TMO_LAST);
  assign w_last_cmd = ((r_idx + 16'd1) == r_count);
  assign w_addr     = r_base + ADDR_W'(r_idx);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (count == 16'd0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          w_next = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_valid) begin
          w_next = w_last_cmd ? ST_DONE : ST_ISSUE;
        end else if (w_tmo_hit) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Outputs: payload is only driven in ISSUE so it reads as zero elsewhere,
  // including immediately under reset.
  always_comb begin
    busy                    = 1'b0;
    done                    = 1'b0;
    cmd_valid               = 1'b0;
    rsp_ready               = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0    = '0;
    cmd_payload_inputs_1    = '0;
    case (r_state)
      ST_ISSUE: begin
        busy                    = 1'b1;
        cmd_valid               = 1'b1;
        rsp_ready               = 1'b1;
        cmd_payload_function_id = r_op ? FN_WRITE : FN_READ;
        cmd_payload_inputs_0    = CFU_DATA_W'(w_addr);
        cmd_payload_inputs_1    = r_op ? (r_seed + 32'(r_idx)) : 32'd0;
      end
      ST_WAIT_RSP: begin
        busy      = 1'b1;
        rsp_ready = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Burst context, index, timeout counter and response accumulation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= 1'b0;
      r_base  <= '0;
      r_count <= '0;
      r_seed  <= '0;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_sum   <= '0;
      r_last  <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= op;
        r_base  <= base_addr;
        r_count <= count;
        r_seed  <= seed;
        r_idx   <= '0;
        r_sum   <= '0;
        r_error <= 1'b0;
      end
      if (w_cmd_fire) begin
        r_tmo <= '0;
      end
      if (w_rsp_fire) begin
        r_last <= rsp_payload_outputs_0;
        r_sum  <= r_sum + rsp_payload_outputs_0;
        r_idx  <= r_idx + 16'd1;
      end else if (r_state == ST_WAIT_RSP) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
      if (w_tmo_hit) begin
        r_error <= 1'b1;
      end
    end
  end

  assign error    = r_error;
  assign sum      = r_sum;
  assign last_rsp = r_last;

endmodule

// File: tb/tb_cfu_burst_initiator.sv
module tb_cfu_burst_initiator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [13:0] base_addr = '0;
  logic [15:0] count = '0;
  logic [31:0] seed = '0;
  logic        busy, done, error;
  logic [31:0] sum, last_rsp;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_data = '0;

  int n_total = 0;
  int n_pass  = 0;

  // Responder environment controls
  bit mute     = 1'b0;
  bit flush    = 1'b0;
  bit rdy_rand = 1'b0;
  int lat_lo   = 1;
  int lat_hi   = 1;

  bit [31:0] env_mem [16384];
  bit [31:0] ref_mem [16384];

  typedef struct {
    logic [9:0]  fn;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;
  cmd_t log_q[$];

  int          outs = 0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;
  bit          prev_stall = 1'b0;
  logic [9:0]  prev_fn = '0;
  logic [31:0] prev_a = '0;
  logic [31:0] prev_d = '0;

  cfu_burst_initiator #(.ADDR_W(14), .TIMEOUT(16)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .start                   (start),
    .op                      (op),
    .base_addr               (base_addr),
    .count                   (count),
    .seed                    (seed),
    .busy                    (busy),
    .done                    (done),
    .error                   (error),
    .sum                     (sum),
    .last_rsp                (last_rsp),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // RAM-style CFU responder: write stores inputs_1 at inputs_0 and echoes it,
  // read returns the word stored at inputs_0 + 8.
  always @(posedge clk) begin
    bit          fc, fr;
    logic [13:0] ra;
    fc = cmd_valid && cmd_ready;
    fr = rsp_valid && rsp_ready;
    if (prev_stall && reset_n) begin
      check("stall_hold_valid", 64'(cmd_valid), 64'd1);
      check("stall_hold_fn", 64'(cmd_payload_function_id), 64'(prev_fn));
      check("stall_hold_in0", 64'(cmd_payload_inputs_0), 64'(prev_a));
      check("stall_hold_in1", 64'(cmd_payload_inputs_1), 64'(prev_d));
    end
    prev_stall = reset_n && cmd_valid && !cmd_ready;
    prev_fn = cmd_payload_function_id;
    prev_a  = cmd_payload_inputs_0;
    prev_d  = cmd_payload_inputs_1;
    if (fr) outs--;
    if (fc) begin
      check("one_outstanding", 64'(outs), 64'd0);
      outs++;
      log_q.push_back('{fn: cmd_payload_function_id, a: cmd_payload_inputs_0, d: cmd_payload_inputs_1});
      if (cmd_payload_function_id == 10'd1) begin
        env_mem[cmd_payload_inputs_0[13:0]] = cmd_payload_inputs_1;
        pend_data = cmd_payload_inputs_1;
      end else begin
        ra = cmd_payload_inputs_0[13:0] + 14'd8;
        pend_data = env_mem[ra];
      end
      pend = 1'b1;
      pend_cnt = $urandom_range(lat_hi, lat_lo);
    end
    #1;
    if (fr) rsp_valid = 1'b0;
    if (pend && !mute) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        rsp_valid = 1'b1;
        rsp_data  = pend_data;
        pend      = 1'b0;
      end
    end
    if (flush) begin
      pend = 1'b0;
      rsp_valid = 1'b0;
      outs = 0;
    end
    cmd_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  // Runs one burst; cyc returns the negedge index (after the start-sampling
  // edge) at which done was observed.
  task automatic run_burst(input bit o, input logic [13:0] b, input logic [15:0] c,
                           input logic [31:0] s, output int cyc);
    cmd_t        exp_q[$];
    logic [31:0] esum, elast, rsp, d;
    logic [13:0] a, ra;
    esum = '0;
    elast = '0;
    for (int i = 0; i < int'(c); i++) begin
      a = b + 14'(i);
      d = o ? (s + 32'(i)) : 32'd0;
      exp_q.push_back('{fn: {9'b0, o}, a: 32'(a), d: d});
      if (o) begin
        ref_mem[a] = d;
        rsp = d;
      end else begin
        ra = a + 14'd8;
        rsp = ref_mem[ra];
      end
      esum += rsp;
      elast = rsp;
    end
    log_q.delete();
    @(negedge clk);
    op = o; base_addr = b; count = c; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = ~o; base_addr = 14'($urandom); count = 16'($urandom); seed = $urandom;
    check("busy_after_start", 64'(busy), 64'd1);
    cyc = 1;
    while (!done && cyc < 2000) begin
      start = (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 64'(done), 64'd1);
    check("burst_error", 64'(error), 64'd0);
    check("burst_sum", 64'(sum), 64'(esum));
    check("burst_last", 64'(last_rsp), 64'(elast));
    check("burst_ncmds", 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check("cmd_fn", 64'(log_q[i].fn), 64'(exp_q[i].fn));
      check("cmd_in0", 64'(log_q[i].a), 64'(exp_q[i].a));
      check("cmd_in1", 64'(log_q[i].d), 64'(exp_q[i].d));
    end
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int  cy, k, wcyc;
    bit  saw;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_rsp_ready", 64'(rsp_ready), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_last", 64'(last_rsp), 64'd0);
    check("rst_in0", 64'(cmd_payload_inputs_0), 64'd0);
    reset_n = 1'b1;

    // Directed write burst
    run_burst(1'b1, 14'h10, 16'd3, 32'h100, cy);
    if (log_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("wr_addr", 64'(log_q[i].a), 64'h10 + 64'(i));
        check("wr_data", 64'(log_q[i].d), 64'h100 + 64'(i));
      end
    end else begin
      check("wr_ncmds", 64'(log_q.size()), 64'd3);
    end

    // Read-back of the same words
    run_burst(1'b0, 14'h08, 16'd3, $urandom, cy);
    check("rd_last", 64'(last_rsp), 64'h102);
    check("rd_sum", 64'(sum), 64'h303);

    // Address wrap
    run_burst(1'b1, 14'h3FFF, 16'd2, 32'hFFFF_FFFF, cy);
    if (log_q.size() == 2) begin
      check("wrap_a0", 64'(log_q[0].a), 64'h3FFF);
      check("wrap_a1", 64'(log_q[1].a), 64'h0000);
      check("wrap_d1", 64'(log_q[1].d), 64'h0);
    end else begin
      check("wrap_ncmds", 64'(log_q.size()), 64'd2);
    end

    // Best-case throughput: 2 cycles per command plus DONE
    run_burst(1'b1, 14'h200, 16'd4, $urandom, cy);
    check("throughput", 64'(cy), 64'd9);

    // Randomized bursts with back-pressure and variable latency
    rdy_rand = 1'b1;
    lat_lo = 1;
    lat_hi = 4;
    for (int t = 0; t < 12; t++) begin
      run_burst(1'($urandom_range(1, 0)), 14'($urandom), 16'($urandom_range(6, 1)), $urandom, cy);
    end
    rdy_rand = 1'b0;
    lat_lo = 1;
    lat_hi = 1;

    // Timeout: responder never answers
    mute = 1'b1;
    log_q.delete();
    @(negedge clk);
    op = 1'b0; base_addr = 14'h40; count = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wcyc = 0;
    k = 0;
    while (!done && k < 200) begin
      if (busy && rsp_ready && !cmd_valid) wcyc++;
      @(negedge clk);
      k++;
    end
    check("tmo_wait_cycles", 64'(wcyc), 64'd16);
    check("tmo_done", 64'(done), 64'd1);
    check("tmo_error", 64'(error), 64'd1);
    check("tmo_ncmds", 64'(log_q.size()), 64'd1);
    check("tmo_sum", 64'(sum), 64'd0);
    @(negedge clk);
    check("tmo_error_sticky", 64'(error), 64'd1);
    check("tmo_idle", 64'(busy), 64'd0);
    mute = 1'b0;
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;

    // Zero-length burst, also clears the sticky error
    log_q.delete();
    @(negedge clk);
    count = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("c0_done", 64'(done), 64'd1);
    check("c0_busy", 64'(busy), 64'd1);
    check("c0_error_cleared", 64'(error), 64'd0);
    check("c0_cmd_valid", 64'(cmd_valid), 64'd0);
    check("c0_rsp_ready", 64'(rsp_ready), 64'd0);
    @(negedge clk);
    check("c0_done_drop", 64'(done), 64'd0);
    check("c0_idle", 64'(busy), 64'd0);
    check("c0_ncmds", 64'(log_q.size()), 64'd0);

    // Reset during WAIT_RSP of command 2 of 5
    lat_lo = 8;
    lat_hi = 8;
    log_q.delete();
    @(negedge clk);
    op = 1'b0; base_addr = 14'h08; count = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (log_q.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("mid_in_wait_busy", 64'(busy), 64'd1);
    check("mid_in_wait_valid", 64'(cmd_valid), 64'd0);
    check("mid_sum_before", 64'(sum), 64'(ref_mem[14'h10]));
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rsp_ready", 64'(rsp_ready), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_last", 64'(last_rsp), 64'd0);
    check("mid_rst_fn", 64'(cmd_payload_function_id), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    check("post_rst_quiet", 64'(saw), 64'd0);
    check("post_rst_sum", 64'(sum), 64'd0);
    check("post_rst_last", 64'(last_rsp), 64'd0);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    lat_lo = 1;
    lat_hi = 1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
